// File: rtl/exec_arb_pkg.sv
// Shared opcodes, port identifiers and request bundle for the exec_arbiter slice.
package exec_arb_pkg;

  localparam int ARB_TAG_W = 5;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic PORT_EX  = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  typedef struct packed {
    logic [63:0]          a;
    logic [63:0]          b;
    logic [63:0]          imm;
    logic                 alusrc;
    logic [3:0]           op;
    logic [ARB_TAG_W-1:0] tag;
  } exec_req_t;

endpackage

// File: rtl/exec_arb_pick.sv
// Two-way grant picker. EXEC_ARB_RR_EN selects round-robin on lastGnt_i; otherwise port 0 always wins.
module exec_arb_pick (
  input  logic [1:0] valid_i,
`ifdef EXEC_ARB_RR_EN
  input  logic       lastGnt_i,
`endif
  output logic [1:0] gnt_o
);

  // A lone requester always wins; contention is resolved by the configured policy.
  always_comb begin
    gnt_o = valid_i;
    if (valid_i == 2'b11) begin
`ifdef EXEC_ARB_RR_EN
      gnt_o = lastGnt_i ? 2'b01 : 2'b10;
`else
      gnt_o = 2'b01;
`endif
    end
  end

endmodule

// File: rtl/execution.sv
// Shared 64-bit ALU datapath: picks B or the immediate, then applies the opcode.
module execution
  import exec_arb_pkg::*;
(
  input  logic [63:0] a_i,
  input  logic [63:0] b_i,
  input  logic [63:0] imm_i,
  input  logic        alusrc_i,
  input  logic [3:0]  op_i,
  output logic [63:0] result_o
);

  logic [63:0] opB;
  logic [5:0]  shamt;

  assign opB   = alusrc_i ? imm_i : b_i;
  assign shamt = opB[5:0];

  // Undefined opcodes fall through to zero.
  always_comb begin
    result_o = '0;
    case (op_i)
      ALU_ADD:  result_o = a_i + opB;
      ALU_SUB:  result_o = a_i - opB;
      ALU_AND:  result_o = a_i & opB;
      ALU_OR:   result_o = a_i | opB;
      ALU_XOR:  result_o = a_i ^ opB;
      ALU_SRL:  result_o = a_i >> shamt;
      ALU_SLL:  result_o = a_i << shamt;
      ALU_SRA:  result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_SLT:  result_o = {63'd0, $signed(a_i) < $signed(opB)};
      ALU_SLTU: result_o = {63'd0, a_i < opB};
      default:  result_o = '0;
    endcase
  end

endmodule

// File: rtl/exec_arbiter.sv
// Shares one execution ALU between the EX stage (port 0) and the secondary issue path (port 1).
// Define EXEC_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module exec_arbiter
  import exec_arb_pkg::*;
#(
  parameter int TAG_W = ARB_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [63:0]      req0_a,
  input  logic [63:0]      req0_b,
  input  logic [63:0]      req0_imm,
  input  logic             req0_alusrc,
  input  logic [3:0]       req0_op,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [63:0]      req1_a,
  input  logic [63:0]      req1_b,
  input  logic [63:0]      req1_imm,
  input  logic             req1_alusrc,
  input  logic [3:0]       req1_op,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_result,
  output logic             out_id,
  output logic [TAG_W-1:0] out_tag
);

  logic              accept;
  logic              xfer;
  logic              winId;
  logic [1:0]        gnt;
  logic [63:0]       aluResult;
  exec_req_t         req0;
  exec_req_t         req1;
  exec_req_t         winReq;
  logic              outValid_q, outValid_d;
  logic [63:0]       outResult_q, outResult_d;
  logic              outId_q, outId_d;
  logic [TAG_W-1:0]  outTag_q, outTag_d;
`ifdef EXEC_ARB_RR_EN
  logic              lastGnt_q;
`endif

  assign req0 = '{a: req0_a, b: req0_b, imm: req0_imm, alusrc: req0_alusrc, op: req0_op, tag: req0_tag};
  assign req1 = '{a: req1_a, b: req1_b, imm: req1_imm, alusrc: req1_alusrc, op: req1_op, tag: req1_tag};

  // Nothing is granted while the output register is full and not being drained.
  assign accept = !outValid_q || out_ready;

  exec_arb_pick uPick (
    .valid_i   ({req1_valid, req0_valid} & {2{accept}}),
`ifdef EXEC_ARB_RR_EN
    .lastGnt_i (lastGnt_q),
`endif
    .gnt_o     (gnt)
  );

  assign xfer       = |gnt;
  assign winId      = gnt[1] ? PORT_AUX : PORT_EX;
  assign winReq     = gnt[1] ? req1 : req0;
  assign req0_ready = accept && gnt[0];
  assign req1_ready = accept && gnt[1];

  execution uExec (
    .a_i      (winReq.a),
    .b_i      (winReq.b),
    .imm_i    (winReq.imm),
    .alusrc_i (winReq.alusrc),
    .op_i     (winReq.op),
    .result_o (aluResult)
  );

  // A transfer reloads the register; otherwise a consume empties it and the payload holds.
  always_comb begin
    outValid_d  = outValid_q && !out_ready;
    outResult_d = outResult_q;
    outId_d     = outId_q;
    outTag_d    = outTag_q;
    if (xfer) begin
      outValid_d  = 1'b1;
      outResult_d = aluResult;
      outId_d     = winId;
      outTag_d    = winReq.tag;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      outValid_q  <= 1'b0;
      outResult_q <= '0;
      outId_q     <= PORT_EX;
      outTag_q    <= '0;
    end else begin
      outValid_q  <= outValid_d;
      outResult_q <= outResult_d;
      outId_q     <= outId_d;
      outTag_q    <= outTag_d;
    end
  end

`ifdef EXEC_ARB_RR_EN
  // Reset to port 1 so port 0 wins the first contended cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lastGnt_q <= PORT_AUX;
    end else if (xfer) begin
      lastGnt_q <= winId;
    end
  end
`endif

  assign out_valid  = outValid_q;
  assign out_result = outResult_q;
  assign out_id     = outId_q;
  assign out_tag    = outTag_q;

endmodule

// File: tb/tb_exec_arbiter.sv
// Scoreboard bench for exec_arbiter: directed cases plus random traffic against a behavioural model.
// Follows EXEC_ARB_RR_EN the same way the design does.
module tb_exec_arbiter;
  import exec_arb_pkg::*;

  localparam int TW = 5;

  typedef struct {
    logic [63:0]   result;
    logic          id;
    logic [TW-1:0] tag;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0_valid, req1_valid;
  logic          req0_ready, req1_ready;
  logic [63:0]   req0_a, req0_b, req0_imm, req1_a, req1_b, req1_imm;
  logic          req0_alusrc, req1_alusrc;
  logic [3:0]    req0_op, req1_op;
  logic [TW-1:0] req0_tag, req1_tag;
  logic          out_valid, out_ready, out_id;
  logic [63:0]   out_result;
  logic [TW-1:0] out_tag;

  int   checks   = 0;
  int   failures = 0;
  exp_t sbQ[$];
  logic modelOutValid;
  logic modelLast;

  always #5 clk = ~clk;

  exec_arbiter #(.TAG_W(TW)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_imm(req0_imm), .req0_alusrc(req0_alusrc), .req0_op(req0_op), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_imm(req1_imm), .req1_alusrc(req1_alusrc), .req1_op(req1_op), .req1_tag(req1_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_id(out_id), .out_tag(out_tag)
  );

  function automatic exec_req_t mkReq(input logic [3:0] op, input logic [63:0] a, input logic [63:0] b,
                                      input logic [63:0] imm, input logic alusrc, input logic [TW-1:0] tag);
    exec_req_t r;
    r.a = a; r.b = b; r.imm = imm; r.alusrc = alusrc; r.op = op; r.tag = tag;
    return r;
  endfunction

  // Reference ALU built from plain arithmetic rather than shift/compare operators where possible.
  function automatic logic [63:0] refResult(input exec_req_t r);
    logic [63:0] x, y, pw, fill;
    int sh;
    x  = r.a;
    y  = r.alusrc ? r.imm : r.b;
    sh = int'(y[5:0]);
    pw = 64'd1 << sh;
    case (r.op)
      4'd0: return x + y;
      4'd1: return x + ~y + 64'd1;
      4'd2: return x & y;
      4'd3: return x | y;
      4'd4: return x ^ y;
      4'd5: return x / pw;
      4'd6: return x * pw;
      4'd7: begin
        fill = x[63] ? ~((~64'd0) / pw) : 64'd0;
        return (x / pw) | fill;
      end
      4'd8: begin
        if (x[63] != y[63]) return {63'd0, x[63]};
        return {63'd0, x < y};
      end
      4'd9: return {63'd0, x < y};
      default: return 64'd0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One cycle: drive at posedge+1, check handshake at negedge+1, update the model.
  task automatic applyStimulus(input logic v0, input exec_req_t p0, input logic v1, input exec_req_t p1,
                               input logic ordy, output logic took0, output logic took1);
    logic acc, win, any;
    exp_t e;
    @(posedge clk); #1;
    req0_valid = v0; req0_a = p0.a; req0_b = p0.b; req0_imm = p0.imm;
    req0_alusrc = p0.alusrc; req0_op = p0.op; req0_tag = p0.tag;
    req1_valid = v1; req1_a = p1.a; req1_b = p1.b; req1_imm = p1.imm;
    req1_alusrc = p1.alusrc; req1_op = p1.op; req1_tag = p1.tag;
    out_ready = ordy;
    @(negedge clk); #1;
    acc = !modelOutValid || ordy;
    any = acc && (v0 || v1);
`ifdef EXEC_ARB_RR_EN
    win = (v0 && v1) ? !modelLast : v1;
`else
    win = v0 ? 1'b0 : 1'b1;
`endif
    checkOutput("out_valid", out_valid, modelOutValid);
    checkOutput("req0_ready", req0_ready, any && !win);
    checkOutput("req1_ready", req1_ready, any && win);
    if (any) begin
      e.result = refResult(win ? p1 : p0);
      e.id     = win;
      e.tag    = win ? p1.tag : p0.tag;
      sbQ.push_back(e);
      modelLast = win;
    end
    modelOutValid = any || (modelOutValid && !ordy);
    took0 = req0_ready;
    took1 = req1_ready;
  endtask

  // Monitor: compare the held result to the scoreboard head every cycle it is presented.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      checkOutput("sb_has_entry", 64'(sbQ.size() != 0), 64'd1);
      if (sbQ.size() != 0) begin
        checkOutput("mon_out_result", out_result, sbQ[0].result);
        checkOutput("mon_out_id", out_id, sbQ[0].id);
        checkOutput("mon_out_tag", out_tag, sbQ[0].tag);
        if (out_ready) void'(sbQ.pop_front());
      end
    end
  end

  // Upstream protocol: a stalled request keeps valid high and its payload unchanged.
  exec_req_t pay0Q, pay1Q;
  logic      hold0Q = 1'b0, hold1Q = 1'b0;
  always @(negedge clk) begin
    if (reset) begin
      hold0Q <= 1'b0;
      hold1Q <= 1'b0;
    end else begin
      if (hold0Q) assert (req0_valid && mkReq(req0_op, req0_a, req0_b, req0_imm, req0_alusrc, req0_tag) == pay0Q)
        else $error("[TB] port 0 request changed while stalled");
      if (hold1Q) assert (req1_valid && mkReq(req1_op, req1_a, req1_b, req1_imm, req1_alusrc, req1_tag) == pay1Q)
        else $error("[TB] port 1 request changed while stalled");
      hold0Q <= req0_valid && !req0_ready;
      hold1Q <= req1_valid && !req1_ready;
      pay0Q  <= mkReq(req0_op, req0_a, req0_b, req0_imm, req0_alusrc, req0_tag);
      pay1Q  <= mkReq(req1_op, req1_a, req1_b, req1_imm, req1_alusrc, req1_tag);
    end
  end

  function automatic exec_req_t rndReq();
    logic [63:0] a, b;
    a = (($urandom % 2) != 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 200));
    b = (($urandom % 2) != 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 70));
    return mkReq(4'($urandom_range(0, 15)), a, b, {$urandom, $urandom} & 64'hFF_FFFF_FFFF,
                 1'($urandom % 2), TW'($urandom));
  endfunction

  initial begin
    exec_req_t none, pXor, pSlt, pSra, pAdd, p0, p1;
    logic t0, t1, pend0, pend1, hold1, ordy;
    logic expId[4];

    none = mkReq(4'd0, 64'd0, 64'd0, 64'd0, 1'b0, '0);
    modelOutValid = 1'b0;
    modelLast     = 1'b1;
    reset = 1'b1; out_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_imm = '0; req0_alusrc = 1'b0; req0_op = '0; req0_tag = '0;
    req1_a = '0; req1_b = '0; req1_imm = '0; req1_alusrc = 1'b0; req1_op = '0; req1_tag = '0;
    #12;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_result", out_result, 0);
    checkOutput("reset_out_id", out_id, 0);
    checkOutput("reset_out_tag", out_tag, 0);
    @(negedge clk); reset = 1'b0;

    // Port 0 ADD 5+7.
    applyStimulus(1, mkReq(ALU_ADD, 64'd5, 64'd7, 64'd0, 1'b0, 5'd3), 0, none, 1, t0, t1);
    applyStimulus(0, none, 0, none, 1, t0, t1);
    checkOutput("add_result", out_result, 64'd12);
    checkOutput("add_id", out_id, 0);
    checkOutput("add_tag", out_tag, 3);

    // Port 1 SUB using the immediate, B ignored.
    applyStimulus(0, none, 1, mkReq(ALU_SUB, 64'd10, 64'd99, 64'd3, 1'b1, 5'd9), 1, t0, t1);
    applyStimulus(0, none, 0, none, 1, t0, t1);
    checkOutput("sub_result", out_result, 64'd7);
    checkOutput("sub_id", out_id, 1);

    // Contention for four cycles.
    pXor = mkReq(ALU_XOR, 64'hF0, 64'h0F, 64'd0, 1'b0, 5'd1);
    pSlt = mkReq(ALU_SLT, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b0, 5'd2);
`ifdef EXEC_ARB_RR_EN
    expId[0] = 0; expId[1] = 1; expId[2] = 0; expId[3] = 1;
`else
    expId[0] = 0; expId[1] = 0; expId[2] = 0; expId[3] = 0;
`endif
    hold1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, pXor, 1, pSlt, 1, t0, t1);
      hold1 = !t1;
      if (k > 0) begin
        checkOutput("contend_id", out_id, expId[k-1]);
        checkOutput("contend_result", out_result, expId[k-1] ? 64'd1 : 64'hFF);
      end
    end
    applyStimulus(0, none, hold1, pSlt, 1, t0, t1);
    if (hold1) hold1 = !t1;
    checkOutput("contend_id_last", out_id, expId[3]);
    for (int k = 0; k < 3 && hold1; k++) begin
      applyStimulus(0, none, 1, pSlt, 1, t0, t1);
      hold1 = !t1;
    end
    applyStimulus(0, none, 0, none, 1, t0, t1);

    // Output stall with an SRA result, a request waiting behind it.
    pSra = mkReq(ALU_SRA, 64'h8000_0000_0000_0000, 64'd4, 64'd0, 1'b0, 5'd4);
    pAdd = mkReq(ALU_ADD, 64'd1, 64'd2, 64'd0, 1'b0, 5'd7);
    applyStimulus(1, pSra, 0, none, 0, t0, t1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, none, 1, pAdd, 0, t0, t1);
      checkOutput("stall_result", out_result, 64'hF800_0000_0000_0000);
      checkOutput("stall_req1_ready", req1_ready, 0);
    end
    applyStimulus(0, none, 1, pAdd, 1, t0, t1);
    checkOutput("stall_release_accept", t1, 1);
    applyStimulus(0, none, 0, none, 1, t0, t1);

    // Reset while a result is held.
    applyStimulus(1, pAdd, 0, none, 1, t0, t1);
    applyStimulus(0, none, 0, none, 0, t0, t1);
    reset = 1'b1;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_out_result", out_result, 0);
    sbQ.delete();
    modelOutValid = 1'b0;
    modelLast     = 1'b1;
    @(negedge clk); reset = 1'b0;
    applyStimulus(1, pXor, 1, pSlt, 1, t0, t1);
    checkOutput("postreset_port0_first", t0, 1);
    applyStimulus(0, none, 1, pSlt, 1, t0, t1);
    applyStimulus(0, none, 0, none, 1, t0, t1);

    // Random traffic.
    pend0 = 1'b0; pend1 = 1'b0; p0 = none; p1 = none;
    for (int n = 0; n < 400; n++) begin
      if (!pend0 && ($urandom % 3) != 0) begin p0 = rndReq(); pend0 = 1'b1; end
      if (!pend1 && ($urandom % 3) != 0) begin p1 = rndReq(); pend1 = 1'b1; end
      ordy = ($urandom % 4) != 0;
      applyStimulus(pend0, p0, pend1, p1, ordy, t0, t1);
      if (t0) pend0 = 1'b0;
      if (t1) pend1 = 1'b0;
    end
    for (int n = 0; n < 10 && (pend0 || pend1); n++) begin
      applyStimulus(pend0, p0, pend1, p1, 1, t0, t1);
      if (t0) pend0 = 1'b0;
      if (t1) pend1 = 1'b0;
    end
    checkOutput("drain_port0", pend0, 0);
    checkOutput("drain_port1", pend1, 0);
    applyStimulus(0, none, 0, none, 1, t0, t1);
    applyStimulus(0, none, 0, none, 1, t0, t1);
    checkOutput("sb_empty", 64'(sbQ.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
